// File: rtl/cart_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cart_bus_arbiter_if
//  Description : Host-side valid/ready request and response channel for the
//                cartridge bus arbiter. The master is the host bridge; the
//                slave is the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cart_bus_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_cs;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;

    modport master (
        output req_valid, req_write, req_cs, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_cs, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cart_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cart_bus_arbiter
//  Description : Owns the cartridge pins and shares them between the Game Boy
//                core (cycle-timed, never stalled mid M-cycle) and a host that
//                issues single setup/strobe/hold accesses while the core is
//                parked. Every pin output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module cart_bus_arbiter #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    // Game Boy core side
    input  wire logic        gb_run_req_i,
    output logic             gb_grant_o,
    input  wire logic [1:0]  gb_tcycle_i,
    input  wire logic        gb_enable_i,
    input  wire logic        gb_write_i,
    input  wire logic        gb_cs_i,
    input  wire logic [15:0] gb_addr_i,
    input  wire logic [7:0]  gb_wdata_i,
    output logic [7:0]       gb_rdata_o,
    // Host request/response channel
    cart_bus_arbiter_if.slave host,
    // Cartridge pins
    output logic [15:0]      cart_a_o,
    output logic [7:0]       cart_dout_o,
    output logic             cart_doe_o,
    input  wire logic [7:0]  cart_din_i,
    output logic             cart_nrd_o,
    output logic             cart_nwr_o,
    output logic             cart_ncs_o
);

    localparam int C_MAX12   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int C_MAXCYC  = (C_MAX12 > HOLD_CYCLES) ? C_MAX12 : HOLD_CYCLES;
    localparam int C_CW      = $clog2(C_MAXCYC + 1);

    // The phase counter is loaded with N-1 on entry and the phase ends when it reads 0
    localparam logic [C_CW-1:0] C_SETUP_LOAD  = C_CW'(SETUP_CYCLES - 1);
    localparam logic [C_CW-1:0] C_STROBE_LOAD = C_CW'(STROBE_CYCLES - 1);
    localparam logic [C_CW-1:0] C_HOLD_LOAD   = C_CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PARKED   = 3'd0,
        S_GB_OWN   = 3'd1,
        S_H_SETUP  = 3'd2,
        S_H_STROBE = 3'd3,
        S_H_HOLD   = 3'd4,
        S_H_RESP   = 3'd5
    } state_t;

    state_t          state_q;
    logic [C_CW-1:0] phase_q;
    logic            wr_q;
    logic            gb_grant_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic [15:0]     cart_a_q;
    logic [7:0]      cart_dout_q;
    logic            cart_doe_q;
    logic            cart_nrd_q;
    logic            cart_nwr_q;
    logic            cart_ncs_q;

    assign gb_grant_o     = gb_grant_q;
    assign gb_rdata_o     = cart_din_i;
    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign cart_a_o       = cart_a_q;
    assign cart_dout_o    = cart_dout_q;
    assign cart_doe_o     = cart_doe_q;
    assign cart_nrd_o     = cart_nrd_q;
    assign cart_nwr_o     = cart_nwr_q;
    assign cart_ncs_o     = cart_ncs_q;

    // Bus ownership FSM; all pin and handshake outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PARKED;
            phase_q     <= '0;
            wr_q        <= 1'b0;
            gb_grant_q  <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            cart_a_q    <= 16'h0000;
            cart_dout_q <= 8'h00;
            cart_doe_q  <= 1'b0;
            cart_nrd_q  <= 1'b1;
            cart_nwr_q  <= 1'b1;
            cart_ncs_q  <= 1'b1;
        end else begin
            // Acceptance is a single-cycle pulse
            req_ready_q <= 1'b0;
            case (state_q)
                S_PARKED: begin
                    cart_nrd_q <= 1'b1;
                    cart_nwr_q <= 1'b1;
                    cart_doe_q <= 1'b0;
                    // The core takes priority over a pending host request
                    if (gb_run_req_i) begin
                        gb_grant_q <= 1'b1;
                        state_q    <= S_GB_OWN;
                    end else if (host.req_valid) begin
                        req_ready_q <= 1'b1;
                        wr_q        <= host.req_write;
                        cart_a_q    <= host.req_addr;
                        cart_ncs_q  <= host.req_cs;
                        cart_dout_q <= host.req_wdata;
                        cart_doe_q  <= host.req_write;
                        rsp_rdata_q <= 8'h00;
                        phase_q     <= C_SETUP_LOAD;
                        state_q     <= S_H_SETUP;
                    end
                end

                S_GB_OWN: begin
                    // Release only on an M-cycle boundary so the core is never cut off mid-access
                    if (!gb_run_req_i && (gb_tcycle_i == 2'd3)) begin
                        gb_grant_q <= 1'b0;
                        cart_nrd_q <= 1'b1;
                        cart_nwr_q <= 1'b1;
                        cart_doe_q <= 1'b0;
                        state_q    <= S_PARKED;
                    end else begin
                        cart_a_q    <= gb_addr_i;
                        cart_ncs_q  <= gb_cs_i;
                        cart_nrd_q  <= ~(gb_enable_i & ~gb_write_i);
                        cart_nwr_q  <= ~(gb_enable_i & gb_write_i &
                                         ((gb_tcycle_i == 2'd1) || (gb_tcycle_i == 2'd2)));
                        cart_doe_q  <= gb_enable_i & gb_write_i;
                        cart_dout_q <= gb_wdata_i;
                    end
                end

                S_H_SETUP: begin
                    if (phase_q == '0) begin
                        cart_nrd_q <= wr_q;
                        cart_nwr_q <= ~wr_q;
                        phase_q    <= C_STROBE_LOAD;
                        state_q    <= S_H_STROBE;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                S_H_STROBE: begin
                    if (phase_q == '0) begin
                        // Read data is taken at the end of the final strobe cycle
                        if (!wr_q) begin
                            rsp_rdata_q <= cart_din_i;
                        end
                        cart_nrd_q <= 1'b1;
                        cart_nwr_q <= 1'b1;
                        phase_q    <= C_HOLD_LOAD;
                        state_q    <= S_H_HOLD;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                S_H_HOLD: begin
                    if (phase_q == '0) begin
                        cart_doe_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_H_RESP;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                S_H_RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_PARKED;
                    end
                end

                default: begin
                    state_q <= S_PARKED;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_bus_arbiter
//  Description : Directed self-checking bench for cart_bus_arbiter. Cycle k
//                of a host access counts from the PARKED cycle in which the
//                request is sampled (k = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        gb_run_req;
    logic        gb_grant;
    logic [1:0]  gb_tcycle;
    logic        gb_enable;
    logic        gb_write;
    logic        gb_cs;
    logic [15:0] gb_addr;
    logic [7:0]  gb_wdata;
    logic [7:0]  gb_rdata;
    logic [15:0] cart_a;
    logic [7:0]  cart_dout;
    logic        cart_doe;
    logic [7:0]  cart_din;
    logic        cart_nrd;
    logic        cart_nwr;
    logic        cart_ncs;

    int n_cmp  = 0;
    int n_fail = 0;

    cart_bus_arbiter_if host_bus ();

    cart_bus_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gb_run_req_i (gb_run_req),
        .gb_grant_o   (gb_grant),
        .gb_tcycle_i  (gb_tcycle),
        .gb_enable_i  (gb_enable),
        .gb_write_i   (gb_write),
        .gb_cs_i      (gb_cs),
        .gb_addr_i    (gb_addr),
        .gb_wdata_i   (gb_wdata),
        .gb_rdata_o   (gb_rdata),
        .host         (host_bus),
        .cart_a_o     (cart_a),
        .cart_dout_o  (cart_dout),
        .cart_doe_o   (cart_doe),
        .cart_din_i   (cart_din),
        .cart_nrd_o   (cart_nrd),
        .cart_nwr_o   (cart_nwr),
        .cart_ncs_o   (cart_ncs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Electrical rule: while a read strobe is active, nothing else may drive the bus
    always @(negedge clk) begin
        if (rst_n && (cart_nrd === 1'b0)) begin
            n_cmp++;
            assert ({cart_nwr, cart_doe} === 2'b10) else begin
                n_fail++;
                $error("FAIL proto_nrd: observed nwr/doe=%b%b expected=10", cart_nwr, cart_doe);
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        gb_run_req         = 1'b0;
        gb_tcycle          = 2'd0;
        gb_enable          = 1'b0;
        gb_write           = 1'b0;
        gb_cs              = 1'b0;
        gb_addr            = 16'h0000;
        gb_wdata           = 8'h00;
        cart_din           = 8'h00;
        host_bus.req_valid = 1'b0;
        host_bus.req_write = 1'b0;
        host_bus.req_cs    = 1'b0;
        host_bus.req_addr  = 16'h0000;
        host_bus.req_wdata = 8'h00;
        host_bus.rsp_ready = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_ctl", {gb_grant, host_bus.req_ready, host_bus.rsp_valid, cart_doe,
                        cart_nrd, cart_nwr, cart_ncs}, 7'b0000111);
        chk("rst_a", cart_a, 16'h0000);
        chk("rst_dout", cart_dout, 8'h00);
        chk("rst_rdata", host_bus.rsp_rdata, 8'h00);

        rst_n = 1'b1;
        step();
        chk("idle_grant", gb_grant, 1'b0);

        // Core read data is the data pins, combinationally
        cart_din = 8'h3C;
        #1;
        chk("gb_rdata", gb_rdata, 8'h3C);

        // Host read 0x0148 (ROM), cart returns 0x05
        host_bus.req_valid = 1'b1;
        host_bus.req_write = 1'b0;
        host_bus.req_cs    = 1'b1;
        host_bus.req_addr  = 16'h0148;
        cart_din           = 8'h05;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("rd_c%0d", k),
                {host_bus.req_ready, host_bus.rsp_valid, cart_nrd, cart_nwr, cart_doe},
                {(k == 1), (k == 8), !(k >= 3 && k <= 6), 1'b1, 1'b0});
            if (k == 1) host_bus.req_valid = 1'b0;
            if (k == 8) begin
                chk("rd_rdata", host_bus.rsp_rdata, 8'h05);
                chk("rd_addr", {cart_ncs, cart_a}, {1'b1, 16'h0148});
            end
        end

        // Back-to-back host write 0xA000 (RAM) = 0x5A
        host_bus.req_valid = 1'b1;
        host_bus.req_write = 1'b1;
        host_bus.req_cs    = 1'b0;
        host_bus.req_addr  = 16'hA000;
        host_bus.req_wdata = 8'h5A;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("wr_c%0d", k),
                {host_bus.req_ready, host_bus.rsp_valid, cart_nrd, cart_nwr, cart_doe},
                {(k == 1), (k == 8), 1'b1, !(k >= 3 && k <= 6), (k >= 1 && k <= 7)});
            if (k == 1) host_bus.req_valid = 1'b0;
            if (k == 4) chk("wr_pins", {cart_ncs, cart_a, cart_dout}, {1'b0, 16'hA000, 8'h5A});
            if (k == 8) chk("wr_rdata", host_bus.rsp_rdata, 8'h00);
        end

        // Core and host both pending in PARKED: core wins
        gb_run_req         = 1'b1;
        host_bus.req_valid = 1'b1;
        host_bus.req_write = 1'b0;
        host_bus.req_cs    = 1'b1;
        host_bus.req_addr  = 16'h0100;
        step();
        chk("prio", {gb_grant, host_bus.req_ready, cart_nrd, cart_nwr, cart_doe}, 5'b10110);

        // Core write 0x2000 = 0x01 over one M-cycle
        gb_enable = 1'b1;
        gb_write  = 1'b1;
        gb_cs     = 1'b1;
        gb_addr   = 16'h2000;
        gb_wdata  = 8'h01;
        for (int t = 0; t <= 3; t++) begin
            gb_tcycle = 2'(t);
            step();
            chk($sformatf("gbw_t%0d", t),
                {gb_grant, host_bus.req_ready, cart_nrd, cart_nwr, cart_doe},
                {1'b1, 1'b0, 1'b1, !(t == 1 || t == 2), 1'b1});
            chk($sformatf("gbw_a_t%0d", t), {cart_a, cart_dout}, {16'h2000, 8'h01});
        end

        // Run request dropped at tcycle 1 while host waits: grant holds to tcycle 3
        gb_enable = 1'b0;
        gb_write  = 1'b0;
        gb_tcycle = 2'd0;
        step();
        gb_tcycle  = 2'd1;
        gb_run_req = 1'b0;
        step();
        chk("drop_t1", gb_grant, 1'b1);
        gb_tcycle = 2'd2;
        step();
        chk("drop_t2", gb_grant, 1'b1);
        gb_tcycle = 2'd3;
        step();
        chk("drop_t3", {gb_grant, host_bus.req_ready, cart_nwr, cart_doe}, 4'b0010);

        // Host read proceeds; core requests the bus mid-strobe; response stalled one cycle
        cart_din = 8'hC3;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("pre_c%0d", k),
                {gb_grant, host_bus.req_ready, host_bus.rsp_valid, cart_nrd, cart_nwr},
                {(k == 11), (k == 1), (k == 8 || k == 9), !(k >= 3 && k <= 6), 1'b1});
            if (k == 1) host_bus.req_valid = 1'b0;
            if (k == 3) gb_run_req = 1'b1;
            if (k == 7) host_bus.rsp_ready = 1'b0;
            if (k == 9) begin
                chk("pre_rdata", host_bus.rsp_rdata, 8'hC3);
                host_bus.rsp_ready = 1'b1;
            end
        end

        // Park the core on an M-cycle boundary, then reset in the middle of a host write strobe
        gb_run_req = 1'b0;
        step();
        chk("park", gb_grant, 1'b0);
        host_bus.req_valid = 1'b1;
        host_bus.req_write = 1'b1;
        host_bus.req_cs    = 1'b0;
        host_bus.req_addr  = 16'h4000;
        host_bus.req_wdata = 8'hAA;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) host_bus.req_valid = 1'b0;
        end
        chk("rst_pre", {cart_nwr, cart_doe}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {gb_grant, host_bus.rsp_valid, cart_doe, cart_nrd, cart_nwr, cart_ncs},
            6'b000111);
        chk("rst_async_a", cart_a, 16'h0000);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("rst_norsp_%0d", k), {gb_grant, host_bus.rsp_valid}, 2'b00);
        end

        // A fresh host read is accepted at once, proving the FSM is PARKED
        host_bus.req_valid = 1'b1;
        host_bus.req_write = 1'b0;
        host_bus.req_cs    = 1'b1;
        host_bus.req_addr  = 16'h0000;
        cart_din           = 8'h77;
        step();
        chk("post_rst_ready", host_bus.req_ready, 1'b1);
        host_bus.req_valid = 1'b0;
        for (int k = 2; k <= 8; k++) step();
        chk("post_rst_rsp", {host_bus.rsp_valid, host_bus.rsp_rdata}, {1'b1, 8'h77});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
